// File: rtl/ram_dp_be.sv
// ---------------------------------------------------------------------------
// ram_dp_be
//   Simple dual-port RAM (one write port, one read port, single clock) with
//   per-byte write enables, 1- or 2-cycle read latency, selectable
//   read-during-write result, same-address collision flag and an optional
//   hardware clear of every word after reset release.
//
// Parameters
//   D_WIDTH        data word width, multiple of 8
//   A_WIDTH        address width, DEPTH = 2**A_WIDTH
//   RD_LATENCY     1 or 2 cycles from read_en to read_valid
//   RDW_MODE       same-address read-during-write: 0 = old data, 1 = new data
//   CLEAR_ON_RESET 1 = zero all words after reset release, 0 = no clear
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   write_en     write request
//   write_addr   write address
//   write_data   write data
//   write_be     byte enables, bit i covers write_data[8i+7:8i]
//   read_en      read request
//   read_addr    read address
//   read_data    read result, held between reads
//   read_valid   one-cycle pulse, read_data valid
//   busy         clear in progress, all requests ignored
//   collision    one-cycle pulse: same-address read and write accepted
// ---------------------------------------------------------------------------
module ram_dp_be #(
  parameter int D_WIDTH        = 32,
  parameter int A_WIDTH        = 5,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_en,
  input  logic [A_WIDTH-1:0]   write_addr,
  input  logic [D_WIDTH-1:0]   write_data,
  input  logic [D_WIDTH/8-1:0] write_be,
  input  logic                 read_en,
  input  logic [A_WIDTH-1:0]   read_addr,
  output logic [D_WIDTH-1:0]   read_data,
  output logic                 read_valid,
  output logic                 busy,
  output logic                 collision
);

  localparam int DEPTH = 2 ** A_WIDTH;
  localparam int NB    = D_WIDTH / 8;

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  generate
    if ((D_WIDTH % 8) != 0 || D_WIDTH < 8) begin : g_bad_dwidth
      $error("ram_dp_be: D_WIDTH must be a non-zero multiple of 8");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("ram_dp_be: RD_LATENCY must be 1 or 2");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Clear / ready FSM
  // -------------------------------------------------------------------------
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [A_WIDTH-1:0] clr_addr_reg;
  logic [A_WIDTH-1:0] clr_addr_next;
  logic               ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if (CLEAR_ON_RESET != 0) begin
        state_reg <= ST_CLEAR;
      end else begin
        state_reg <= ST_READY;
      end
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  // Next-state logic: one word zeroed per cycle, leave after the last one
  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    case (state_reg)
      ST_CLEAR: begin
        clr_addr_next = clr_addr_reg + 1'b1;
        if (clr_addr_reg == {A_WIDTH{1'b1}}) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
      default: begin
        state_next = ST_READY;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy  = 1'b0;
    ready = 1'b0;
    case (state_reg)
      ST_CLEAR: busy  = 1'b1;
      ST_READY: ready = 1'b1;
      default:  ready = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Request acceptance
  // -------------------------------------------------------------------------
  logic               rd_acc;
  logic               coll_next;
  logic [A_WIDTH-1:0] mem_addr;

  assign rd_acc = ready & read_en;

  // A write with no enabled bytes changes nothing, so it cannot collide.
  assign coll_next = ready & write_en & (|write_be) & read_en &
                     (write_addr == read_addr);

  // During clear the write port is taken over by the clear address.
  assign mem_addr = busy ? clr_addr_reg : write_addr;

  // -------------------------------------------------------------------------
  // Storage: one independent byte-wide array per lane so that each byte
  // enable maps onto its own RAM write enable.
  // -------------------------------------------------------------------------
  logic [D_WIDTH-1:0] rd_raw;
  logic [D_WIDTH-1:0] rd_merged;
  logic               rdw_hit_reg;
  logic [D_WIDTH-1:0] rdw_data_reg;
  logic [NB-1:0]      rdw_be_reg;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic       lane_we;
      logic [7:0] lane_wdata;
      logic [7:0] rd_byte_reg;

      assign lane_we    = busy | (ready & write_en & write_be[gi]);
      assign lane_wdata = busy ? 8'h00 : write_data[gi*8 +: 8];

      // Array is deliberately not reset; clearing is done by the FSM.
      always_ff @(posedge clk) begin
        if (lane_we) begin
          mem[mem_addr] <= lane_wdata;
        end
      end

      // Registered read. The array update is non-blocking, so a same-cycle
      // write to the same address returns the pre-write byte here.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_byte_reg <= 8'h00;
        end else if (rd_acc) begin
          rd_byte_reg <= mem[read_addr];
        end
      end

      assign rd_raw[gi*8 +: 8] = rd_byte_reg;

      // New-data mode: substitute the bytes that were written in the same
      // cycle as the read to the same address.
      assign rd_merged[gi*8 +: 8] =
        ((RDW_MODE != 0) && rdw_hit_reg && rdw_be_reg[gi]) ?
        rdw_data_reg[gi*8 +: 8] : rd_raw[gi*8 +: 8];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // First read stage: valid, collision and the write side-band needed for
  // byte merging. Side-band only advances on an accepted read so that the
  // merged word stays stable while read_data is being held.
  // -------------------------------------------------------------------------
  logic valid1_reg;
  logic collision_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid1_reg    <= 1'b0;
      collision_reg <= 1'b0;
      rdw_hit_reg   <= 1'b0;
      rdw_data_reg  <= '0;
      rdw_be_reg    <= '0;
    end else begin
      valid1_reg    <= rd_acc;
      collision_reg <= coll_next;
      if (rd_acc) begin
        rdw_hit_reg  <= coll_next;
        rdw_data_reg <= write_data;
        rdw_be_reg   <= write_be;
      end
    end
  end

  assign collision = collision_reg;

  // -------------------------------------------------------------------------
  // Optional second output stage
  // -------------------------------------------------------------------------
  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [D_WIDTH-1:0] out_data_reg;
      logic               valid2_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          out_data_reg <= '0;
          valid2_reg   <= 1'b0;
        end else begin
          valid2_reg <= valid1_reg;
          if (valid1_reg) begin
            out_data_reg <= rd_merged;
          end
        end
      end

      assign read_data  = out_data_reg;
      assign read_valid = valid2_reg;
    end else begin : g_lat1
      assign read_data  = rd_merged;
      assign read_valid = valid1_reg;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_be.sv
// ---------------------------------------------------------------------------
// tb_ram_dp_be
//   Directed testbench for ram_dp_be. Four instances share one stimulus:
//     dut0: defaults (RD_LATENCY=1, RDW_MODE=0, CLEAR_ON_RESET=1)
//     dut1: RDW_MODE=1
//     dut2: RD_LATENCY=2
//     dut3: CLEAR_ON_RESET=0
// ---------------------------------------------------------------------------
module tb_ram_dp_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [3:0]  be;
  logic        re;
  logic [4:0]  ra;

  logic [31:0] rd0, rd1, rd2, rd3;
  logic        rv0, rv1, rv2, rv3;
  logic        busy0, busy1, busy2, busy3;
  logic        col0, col1, col2, col3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_dp_be dut0 (
    .clk(clk), .rst(rst), .write_en(we), .write_addr(wa), .write_data(wd),
    .write_be(be), .read_en(re), .read_addr(ra), .read_data(rd0),
    .read_valid(rv0), .busy(busy0), .collision(col0)
  );

  ram_dp_be #(.RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .write_en(we), .write_addr(wa), .write_data(wd),
    .write_be(be), .read_en(re), .read_addr(ra), .read_data(rd1),
    .read_valid(rv1), .busy(busy1), .collision(col1)
  );

  ram_dp_be #(.RD_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .write_en(we), .write_addr(wa), .write_data(wd),
    .write_be(be), .read_en(re), .read_addr(ra), .read_data(rd2),
    .read_valid(rv2), .busy(busy2), .collision(col2)
  );

  ram_dp_be #(.CLEAR_ON_RESET(0)) dut3 (
    .clk(clk), .rst(rst), .write_en(we), .write_addr(wa), .write_data(wd),
    .write_be(be), .read_en(re), .read_addr(ra), .read_data(rd3),
    .read_valid(rv3), .busy(busy3), .collision(col3)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-24s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; be = 4'h0; re = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] b);
    we = 1'b1; wa = a; wd = d; be = b;
  endtask

  task automatic rdreq(input logic [4:0] a);
    re = 1'b1; ra = a;
  endtask

  // Counts cycles with busy high, starting with the cycle in which reset was
  // released; bounded so a stuck busy still ends the run.
  task automatic count_busy(output int n, output logic stray);
    n = 1;
    stray = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      stray = stray | rv0 | rv1 | rv2 | col0 | col1 | col2;
      if (busy0) n++;
      else break;
    end
  endtask

  int   nbusy;
  logic stray;

  initial begin
    rst = 1'b0; we = 1'b0; wa = '0; wd = '0; be = '0; re = 1'b0; ra = '0;
    step();
    step();

    // ---- reset state ----
    check("rst_busy0", {31'd0, busy0}, 32'd1);
    check("rst_busy3", {31'd0, busy3}, 32'd0);
    check("rst_valid0", {31'd0, rv0}, 32'd0);
    check("rst_data0", rd0, 32'd0);
    check("rst_data2", rd2, 32'd0);
    check("rst_coll0", {31'd0, col0}, 32'd0);

    // ---- 1: clear after release, requests ignored while busy ----
    rst = 1'b1;
    wr(5'd5, 32'hFFFF_FFFF, 4'hF);
    rdreq(5'd5);
    count_busy(nbusy, stray);
    idle();
    check("clear_busy_cycles", nbusy, 32'd32);
    check("clear_no_valid_coll", {31'd0, stray}, 32'd0);
    check("clear_busy2_done", {31'd0, busy2}, 32'd0);
    rdreq(5'd5);
    step();
    check("t1_valid0", {31'd0, rv0}, 32'd1);
    check("t1_data0", rd0, 32'd0);
    check("t1_valid2_early", {31'd0, rv2}, 32'd0);
    idle();
    step();
    check("t1_valid0_pulse", {31'd0, rv0}, 32'd0);
    check("t1_valid2", {31'd0, rv2}, 32'd1);
    check("t1_data2", rd2, 32'd0);

    // ---- 2: full and partial byte writes ----
    wr(5'd3, 32'hDEAD_BEEF, 4'hF);
    step();
    idle();
    rdreq(5'd3);
    step();
    check("t2_valid0", {31'd0, rv0}, 32'd1);
    check("t2_data0", rd0, 32'hDEAD_BEEF);
    check("t2_valid3", {31'd0, rv3}, 32'd1);
    check("t2_data3", rd3, 32'hDEAD_BEEF);
    idle();
    wr(5'd3, 32'h1122_3344, 4'b0101);
    step();
    idle();
    rdreq(5'd3);
    step();
    check("t2_be0101_data0", rd0, 32'hDE22_BE44);
    check("t2_be0101_data3", rd3, 32'hDE22_BE44);
    idle();
    step();
    check("t2_hold_valid0", {31'd0, rv0}, 32'd0);
    check("t2_hold_data0", rd0, 32'hDE22_BE44);

    // ---- 3: same-address read-during-write ----
    wr(5'd7, 32'hAAAA_AAAA, 4'hF);
    step();
    wr(5'd7, 32'h5555_5555, 4'hF);
    rdreq(5'd7);
    step();
    check("t3_old_data0", rd0, 32'hAAAA_AAAA);
    check("t3_coll0", {31'd0, col0}, 32'd1);
    check("t3_new_data1", rd1, 32'h5555_5555);
    check("t3_coll1", {31'd0, col1}, 32'd1);
    idle();
    rdreq(5'd7);
    step();
    check("t3_coll0_pulse", {31'd0, col0}, 32'd0);
    check("t3_followup0", rd0, 32'h5555_5555);
    idle();
    wr(5'd7, 32'hAAAA_AAAA, 4'hF);
    step();
    wr(5'd7, 32'h5555_5555, 4'b0011);
    rdreq(5'd7);
    step();
    check("t3_be0011_old0", rd0, 32'hAAAA_AAAA);
    check("t3_be0011_merged1", rd1, 32'hAAAA_5555);
    idle();
    rdreq(5'd7);
    step();
    check("t3_be0011_stored0", rd0, 32'hAAAA_5555);
    check("t3_be0011_stored1", rd1, 32'hAAAA_5555);
    idle();

    // ---- 4: latency-2 pipelined reads ----
    for (int i = 0; i < 4; i++) begin
      wr(5'(i), 32'h10 + 32'(i), 4'hF);
      step();
    end
    idle();
    rdreq(5'd0);
    step();
    check("t4_c1_valid2", {31'd0, rv2}, 32'd0);
    check("t4_c1_data0", rd0, 32'h10);
    rdreq(5'd1);
    step();
    check("t4_c2_valid2", {31'd0, rv2}, 32'd1);
    check("t4_c2_data2", rd2, 32'h10);
    rdreq(5'd2);
    step();
    check("t4_c3_data2", rd2, 32'h11);
    rdreq(5'd3);
    step();
    check("t4_c4_data2", rd2, 32'h12);
    idle();
    step();
    check("t4_c5_valid2", {31'd0, rv2}, 32'd1);
    check("t4_c5_data2", rd2, 32'h13);
    step();
    check("t4_c6_valid2", {31'd0, rv2}, 32'd0);
    check("t4_c6_hold2", rd2, 32'h13);

    // ---- 6: independent ports, zero byte-enable write ----
    wr(5'd9, 32'h0000_0099, 4'hF);
    step();
    wr(5'd4, 32'h4444_4444, 4'hF);
    rdreq(5'd9);
    step();
    check("t6_diff_coll0", {31'd0, col0}, 32'd0);
    check("t6_diff_data0", rd0, 32'h0000_0099);
    wr(5'd9, 32'hFFFF_FFFF, 4'h0);
    rdreq(5'd9);
    step();
    check("t6_be0_coll0", {31'd0, col0}, 32'd0);
    idle();
    rdreq(5'd9);
    step();
    check("t6_be0_data0", rd0, 32'h0000_0099);
    rdreq(5'd4);
    step();
    check("t6_addr4_data0", rd0, 32'h4444_4444);
    idle();

    // ---- 5: reset during clear restarts it ----
    wr(5'd31, 32'hCAFE_F00D, 4'hF);
    step();
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("t5_busy_mid", {31'd0, busy0}, 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    count_busy(nbusy, stray);
    check("t5_busy_cycles", nbusy, 32'd32);
    rdreq(5'd31);
    step();
    check("t5_addr31_cleared", rd0, 32'd0);
    rdreq(5'd3);
    step();
    check("t5_addr3_cleared", rd0, 32'd0);
    idle();
    wr(5'd31, 32'h1, 4'hF);
    step();
    wr(5'd0, 32'h2, 4'hF);
    step();
    idle();
    rdreq(5'd31);
    step();
    check("t5_addr31", rd0, 32'h1);
    rdreq(5'd0);
    step();
    check("t5_addr0", rd0, 32'h2);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
